// File: rtl/ffs_wrr_pkt_sched_pkg.sv
// Shared types and helpers for the packet-level weighted round-robin scheduler.
// The helpers work on full 16-client / 8-bit-weight vectors; callers zero-extend.
package ffs_sched_pkg;

   localparam int MAX_CLIENTS  = 16;
   localparam int IDX_W        = 4;
   localparam int MAX_WEIGHT_W = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Highest set bit strictly below ptr; if none (or ptr not yet valid),
   // highest set bit overall. Returns {vld, idx}.
   function automatic logic [IDX_W:0] rr_pick(input logic [MAX_CLIENTS-1:0] vector,
                                              input logic [IDX_W-1:0]       ptr,
                                              input logic                   ptr_vld);
      logic             found_v;
      logic [IDX_W-1:0] idx_v;
      found_v = 1'b0;
      idx_v   = '0;
      // Ascending scan: the last hit is the highest qualifying index.
      for (int i = 0; i < MAX_CLIENTS; i++) begin
         if (ptr_vld && (i < int'(ptr)) && vector[i]) begin
            found_v = 1'b1;
            idx_v   = IDX_W'(i);
         end else begin
            found_v = found_v;
         end
      end
      if (!found_v) begin
         for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (vector[i]) begin
               found_v = 1'b1;
               idx_v   = IDX_W'(i);
            end else begin
               found_v = found_v;
            end
         end
      end else begin
         found_v = found_v;
      end
      return {found_v, idx_v};
   endfunction

   // Packets-per-turn for client idx; a programmed 0 behaves as 1.
   function automatic logic [MAX_WEIGHT_W-1:0] weight_of(input logic [MAX_CLIENTS*MAX_WEIGHT_W-1:0] cfg,
                                                        input logic [IDX_W-1:0]                    idx);
      logic [MAX_WEIGHT_W-1:0] w_v;
      w_v = cfg[int'(idx)*MAX_WEIGHT_W +: MAX_WEIGHT_W];
      if (w_v == 8'd0) begin
         w_v = 8'd1;
      end else begin
         w_v = w_v;
      end
      return w_v;
   endfunction

endpackage

// File: rtl/ffs_rr_pick.sv
// Combinational rotating highest-set-bit search over the request vector.
module ffs_rr_pick
   import ffs_sched_pkg::*;
#(
   parameter int CLIENTS = 16
) (
   input  logic [CLIENTS-1:0] vector,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               ptr_vld,
   output logic               pick_vld,
   output logic [IDX_W-1:0]   pick_idx
);

   logic [MAX_CLIENTS-1:0] vec_wide_s;
   logic [IDX_W:0]         res_s;

   // Widen the request vector to the helper's fixed width and search it.
   always_comb begin
      vec_wide_s                = '0;
      vec_wide_s[CLIENTS-1:0]   = vector;
      res_s                     = rr_pick(vec_wide_s, ptr, ptr_vld);
   end

   assign pick_vld = res_s[IDX_W];
   assign pick_idx = res_s[IDX_W-1:0];

endmodule

// File: rtl/ffs_wrr_pkt_sched.sv
// Packet-level weighted round-robin scheduler: holds a one-hot grant for a
// whole packet and lets a client keep the channel for up to its weight of
// packets before rotating to the next requester with zero idle cycles.
module ffs_wrr_pkt_sched
   import ffs_sched_pkg::*;
#(
   parameter int CLIENTS  = 16,
   parameter int WEIGHT_W = 4,
   parameter int ID_W     = $clog2(CLIENTS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CLIENTS-1:0]           req,
   input  logic [CLIENTS-1:0]           last,
   input  logic                         ready,
   input  logic [CLIENTS*WEIGHT_W-1:0]  cfg_weight,
   output logic [CLIENTS-1:0]           gnt,
   output logic                         gnt_vld,
   output logic [ID_W-1:0]              gnt_id,
   output logic                         xfer,
   output logic                         err
);

   state_t                          state_r, state_nxt_s;
   logic [CLIENTS-1:0]              gnt_r, gnt_nxt_s;
   logic [ID_W-1:0]                 gnt_id_r, gnt_id_nxt_s;
   logic [ID_W-1:0]                 ptr_r, ptr_nxt_s;
   logic                            ptr_vld_r, ptr_vld_nxt_s;
   logic [WEIGHT_W-1:0]             credit_r, credit_nxt_s;
   logic                            err_r, err_nxt_s;

   logic [MAX_CLIENTS*MAX_WEIGHT_W-1:0] cfg_wide_s;
   logic [IDX_W-1:0]                ptr_ext_s;
   logic [CLIENTS-1:0]              req_masked_s;
   logic                            pick_vld_s, mpick_vld_s;
   logic [IDX_W-1:0]                pick_idx_s, mpick_idx_s;
   logic [WEIGHT_W-1:0]             w_pick_s, w_mpick_s, w_hold_s;
   logic [WEIGHT_W-1:0]             credit_dec_s;
   logic                            holder_req_s, last_xfer_s, keep_s;

   // Clip a widened weight into the credit counter range.
   function automatic logic [WEIGHT_W-1:0] clip_w(input logic [MAX_WEIGHT_W-1:0] w);
      logic [WEIGHT_W-1:0] c_v;
      if ((w >> WEIGHT_W) != '0) begin
         c_v = '1;
      end else begin
         c_v = w[WEIGHT_W-1:0];
      end
      return c_v;
   endfunction

   // Repack per-client weights into the helper's fixed field layout.
   always_comb begin
      cfg_wide_s = '0;
      for (int i = 0; i < CLIENTS; i++) begin
         cfg_wide_s[i*MAX_WEIGHT_W +: WEIGHT_W] = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
      end
   end

   assign ptr_ext_s    = IDX_W'(ptr_r);
   assign req_masked_s = req & ~gnt_r;

   ffs_rr_pick #(.CLIENTS(CLIENTS)) u_pick (
      .vector   (req),
      .ptr      (ptr_ext_s),
      .ptr_vld  (ptr_vld_r),
      .pick_vld (pick_vld_s),
      .pick_idx (pick_idx_s)
   );

   // Holder-masked pick used at packet boundaries; ptr always equals the holder here.
   ffs_rr_pick #(.CLIENTS(CLIENTS)) u_mpick (
      .vector   (req_masked_s),
      .ptr      (ptr_ext_s),
      .ptr_vld  (1'b1),
      .pick_vld (mpick_vld_s),
      .pick_idx (mpick_idx_s)
   );

   assign w_pick_s     = clip_w(weight_of(cfg_wide_s, pick_idx_s));
   assign w_mpick_s    = clip_w(weight_of(cfg_wide_s, mpick_idx_s));
   assign w_hold_s     = clip_w(weight_of(cfg_wide_s, IDX_W'(gnt_id_r)));

   assign holder_req_s = req[gnt_id_r];
   assign last_xfer_s  = xfer & last[gnt_id_r];
   assign credit_dec_s = (credit_r != '0) ? (credit_r - WEIGHT_W'(1'b1)) : '0;
   assign keep_s       = (credit_dec_s != '0) & holder_req_s;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decision: leave HOLD only when a packet ends and nobody requests.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (pick_vld_s) state_nxt_s = HOLD;
            else            state_nxt_s = IDLE;
         end
         HOLD: begin
            if (last_xfer_s && !keep_s && !mpick_vld_s && !holder_req_s) state_nxt_s = IDLE;
            else                                                         state_nxt_s = HOLD;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values of grant, credit, rotation pointer and error flag.
   always_comb begin
      gnt_nxt_s     = gnt_r;
      gnt_id_nxt_s  = gnt_id_r;
      credit_nxt_s  = credit_r;
      ptr_nxt_s     = ptr_r;
      ptr_vld_nxt_s = ptr_vld_r;
      err_nxt_s     = err_r;
      case (state_r)
         IDLE: begin
            if (pick_vld_s) begin
               gnt_nxt_s     = {{(CLIENTS-1){1'b0}}, 1'b1} << pick_idx_s;
               gnt_id_nxt_s  = pick_idx_s[ID_W-1:0];
               credit_nxt_s  = w_pick_s;
               ptr_nxt_s     = pick_idx_s[ID_W-1:0];
               ptr_vld_nxt_s = 1'b1;
            end else begin
               gnt_nxt_s     = '0;
               gnt_id_nxt_s  = '0;
            end
         end
         HOLD: begin
            if (!holder_req_s) err_nxt_s = 1'b1;
            else               err_nxt_s = err_r;
            if (last_xfer_s) begin
               if (keep_s) begin
                  credit_nxt_s = credit_dec_s;
               end else if (mpick_vld_s) begin
                  gnt_nxt_s    = {{(CLIENTS-1){1'b0}}, 1'b1} << mpick_idx_s;
                  gnt_id_nxt_s = mpick_idx_s[ID_W-1:0];
                  credit_nxt_s = w_mpick_s;
                  ptr_nxt_s    = mpick_idx_s[ID_W-1:0];
               end else if (holder_req_s) begin
                  credit_nxt_s = w_hold_s;
               end else begin
                  gnt_nxt_s    = '0;
                  gnt_id_nxt_s = '0;
                  credit_nxt_s = credit_dec_s;
               end
            end else begin
               credit_nxt_s = credit_r;
            end
         end
         default: begin
            gnt_nxt_s    = '0;
            gnt_id_nxt_s = '0;
         end
      endcase
   end

   // Grant, credit, pointer and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_r     <= '0;
         gnt_id_r  <= '0;
         credit_r  <= '0;
         ptr_r     <= '0;
         ptr_vld_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         gnt_r     <= gnt_nxt_s;
         gnt_id_r  <= gnt_id_nxt_s;
         credit_r  <= credit_nxt_s;
         ptr_r     <= ptr_nxt_s;
         ptr_vld_r <= ptr_vld_nxt_s;
         err_r     <= err_nxt_s;
      end
   end

   assign gnt     = gnt_r;
   assign gnt_vld = |gnt_r;
   assign gnt_id  = gnt_id_r;
   assign xfer    = gnt_vld & holder_req_s & ready;
   assign err     = err_r;

endmodule

// File: tb/tb_ffs_wrr_pkt_sched.sv
// Scoreboard bench for ffs_wrr_pkt_sched with CLIENTS=4: directed scenarios
// plus random traffic checked against a rotating-order reference model.
module tb_ffs_wrr_pkt_sched;

   localparam int N  = 4;
   localparam int WW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, last;
   logic            ready;
   logic [N*WW-1:0] cfg_weight;
   logic [N-1:0]    gnt;
   logic            gnt_vld;
   logic [1:0]      gnt_id;
   logic            xfer;
   logic            err;

   ffs_wrr_pkt_sched #(.CLIENTS(N), .WEIGHT_W(WW)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last), .ready(ready),
      .cfg_weight(cfg_weight), .gnt(gnt), .gnt_vld(gnt_vld),
      .gnt_id(gnt_id), .xfer(xfer), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] g;
      logic [1:0] id;
      logic       vld;
      logic       e;
   } exp_t;

   exp_t sq[$];
   logic xq[$];

   // Reference model state
   bit m_hold, m_ptr_vld, m_err;
   int m_holder, m_credit, m_ptr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int wt(input int c);
      int w;
      w = int'(cfg_weight[c*WW +: WW]);
      return (w == 0) ? 1 : w;
   endfunction

   // Candidates in rotation order: just below the previous winner downward, wrapping.
   function automatic int pick(input logic [3:0] r, input int excl);
      int start, c;
      start = m_ptr_vld ? m_ptr : N;
      for (int k = 1; k <= N; k++) begin
         c = (start - k + 2 * N) % N;
         if (r[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_hold = 0; m_ptr_vld = 0; m_err = 0;
      m_holder = 0; m_credit = 0; m_ptr = 0;
   endtask

   task automatic m_grant(input int p);
      m_hold = 1; m_holder = p; m_credit = wt(p); m_ptr = p; m_ptr_vld = 1;
   endtask

   // Evaluate current inputs against the model and queue expectations.
   task automatic model_eval();
      bit   x;
      int   p;
      exp_t e;
      x = m_hold && req[m_holder] && ready;
      xq.push_back(x);
      if (m_hold && !req[m_holder]) m_err = 1;
      if (!m_hold) begin
         p = pick(req, -1);
         if (p >= 0) m_grant(p);
      end else if (x && last[m_holder]) begin
         if (m_credit > 0) m_credit--;
         if (!(m_credit > 0 && req[m_holder])) begin
            p = pick(req, m_holder);
            if (p >= 0)              m_grant(p);
            else if (req[m_holder])  m_credit = wt(m_holder);
            else                     m_hold = 0;
         end
      end
      e.g   = m_hold ? 4'(1 << m_holder) : 4'd0;
      e.id  = m_hold ? 2'(m_holder) : 2'd0;
      e.vld = m_hold;
      e.e   = m_err;
      sq.push_back(e);
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rd);
      req = r; last = l; ready = rd;
      model_eval();
      @(posedge clk); #2;
   endtask

   task automatic do_reset(input logic [15:0] w);
      rst = 1'b1; req = '0; last = '0; ready = 1'b0; cfg_weight = w;
      @(posedge clk); #2;
      rst = 1'b0;
      m_reset();
   endtask

   // Monitor: combinational xfer checked mid-cycle
   always @(negedge clk) begin
      logic ex;
      if (xq.size() > 0) begin
         ex = xq.pop_front();
         chk("xfer", 32'(xfer), 32'(ex));
      end
   end

   // Monitor: registered outputs checked just after the edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sq.size() > 0) begin
         e = sq.pop_front();
         chk("gnt", 32'(gnt), 32'(e.g));
         chk("gnt_id", 32'(gnt_id), 32'(e.id));
         chk("gnt_vld", 32'(gnt_vld), 32'(e.vld));
         chk("err", 32'(err), 32'(e.e));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int exp1[4];
      int exp2[8];
      int b;
      logic [3:0] r, l;
      logic [15:0] w;
      exp1 = '{3, 1, 3, 1};
      exp2 = '{3, 3, 3, 0, 3, 3, 3, 0};

      rst = 1'b1; req = '0; last = '0; ready = 1'b0; cfg_weight = 16'h1111;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_gnt_vld", 32'(gnt_vld), 32'd0);
      chk("rst_gnt_id", 32'(gnt_id), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      m_reset();

      // Alternating clients 3 and 1, weight 1
      for (int k = 0; k < 4; k++) begin
         step(4'b1010, 4'b1010, 1'b1);
         chk("c1_order", 32'(gnt_id), 32'(exp1[k]));
      end

      // Client 3 weight 3 vs client 0
      do_reset(16'h3111);
      for (int k = 0; k < 8; k++) begin
         step(4'b1001, 4'b1001, 1'b1);
         chk("c2_order", 32'(gnt_id), 32'(exp2[k]));
      end

      // Client 2, 4-beat packet with ready toggling
      do_reset(16'h1111);
      step(4'b0100, 4'b0000, 1'b0);
      chk("c3_first", 32'(gnt), 32'h4);
      b = 0;
      for (int k = 0; k < 7; k++) begin
         step(4'b0100, (b == 3) ? 4'b0100 : 4'b0000, (k % 2 == 0) ? 1'b1 : 1'b0);
         if (k % 2 == 0) b++;
         chk("c3_hold", 32'(gnt), 32'h4);
      end

      // Client 1 drops req mid-packet
      do_reset(16'h1111);
      step(4'b0010, 4'b0000, 1'b1);
      step(4'b0010, 4'b0000, 1'b1);
      step(4'b0000, 4'b0000, 1'b1);
      step(4'b0000, 4'b0000, 1'b1);
      chk("c4_err", 32'(err), 32'd1);
      chk("c4_gnt", 32'(gnt), 32'h2);
      step(4'b0010, 4'b0010, 1'b1);
      chk("c4_err_sticky", 32'(err), 32'd1);

      // Asynchronous reset mid-packet
      do_reset(16'h1111);
      step(4'b0001, 4'b0000, 1'b1);
      step(4'b0001, 4'b0000, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("c5_async_gnt", 32'(gnt), 32'd0);
      chk("c5_async_vld", 32'(gnt_vld), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      m_reset();
      step(4'b1111, 4'b0000, 1'b1);
      chk("c5_restart", 32'(gnt_id), 32'd3);

      // Weight 0 on client 0
      do_reset(16'h1110);
      for (int k = 0; k < 6; k++) begin
         step(4'b0001, 4'b0001, 1'b1);
         chk("c6_w0", 32'(gnt), 32'h1);
      end

      // Random legal traffic, then traffic with occasional req drops
      for (int ph = 0; ph < 2; ph++) begin
         w = 16'($urandom);
         w = w & 16'h3333;
         do_reset(w);
         for (int k = 0; k < 1500; k++) begin
            r = 4'($urandom);
            l = 4'($urandom);
            if (m_hold) begin
               if (ph == 0 || $urandom_range(0, 15) != 0) r[m_holder] = 1'b1;
               else                                      r[m_holder] = 1'b0;
            end
            step(r, l, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
